// File: rtl/gc_pad_apb_if.sv
`default_nettype none
// ============================================================================
//  Module   : gc_pad_apb_if
//  Purpose  : APB3 bus bundle between the MSS APB master and the GameCube
//             pad poller.
//  Signals  : PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[31:0]  (master -> slave)
//             PRDATA[31:0], PREADY, PSLVERR                     (slave -> master)
//  Modports : master, slave
//  Revision : 1.0  initial release
// ============================================================================
interface gc_pad_apb_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/gc_pad_apb.sv
`default_nettype none
// ============================================================================
//  Module   : gc_pad_apb
//  Purpose  : APB3 slave that polls one GameCube controller over its
//             single-wire open-drain line and captures the 64-bit reply.
//             The line is only ever pulled low (GC_DATA_OE=1) or released.
//  Ports    : FAB_CLK      - sole clock
//             M2F_RESET_N  - asynchronous active-low reset
//             apb          - APB3 slave bundle (gc_pad_apb_if.slave)
//             GC_DATA_OE   - 1 = pull GC line low
//             GC_DATA_IN   - GC line level (asynchronous, synchronised here)
//             GC_IRQ       - DONE | TIMEOUT (only with GC_PAD_IRQ_EN)
//  Registers: 0x00 CTRL    [0] START (self-clear) [1] AUTO [2] RUMBLE
//             0x04 STATUS  [0] BUSY [1] DONE (W1C) [2] TIMEOUT (W1C)
//             0x08 DATA_HI response[63:32]
//             0x0C DATA_LO response[31:0]
//  Config   : define GC_PAD_IRQ_EN to add the registered GC_IRQ output.
//  Revision : 1.0  initial release
// ============================================================================
module gc_pad_apb #(
  parameter int CLK_PER_US    = 10,
  parameter int RX_TIMEOUT_US = 100,
  parameter int POLL_GAP_US   = 1000
) (
  input  wire          FAB_CLK,
  input  wire          M2F_RESET_N,
  gc_pad_apb_if.slave  apb,
  output logic         GC_DATA_OE,
  input  wire          GC_DATA_IN
`ifdef GC_PAD_IRQ_EN
  ,
  output logic         GC_IRQ
`endif
);

  localparam int c_TO_CYC  = RX_TIMEOUT_US * CLK_PER_US;
  localparam int c_GAP_CYC = POLL_GAP_US * CLK_PER_US;
  localparam int c_BIT_CYC = 4 * CLK_PER_US;
  localparam int c_MAX_A   = (c_GAP_CYC > c_TO_CYC) ? c_GAP_CYC : c_TO_CYC;
  localparam int c_MAX_CYC = (c_MAX_A > c_BIT_CYC) ? c_MAX_A : c_BIT_CYC;
  localparam int c_TW      = $clog2(c_MAX_CYC + 1);

  // Timer reload values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [c_TW-1:0] c_T1US = c_TW'(CLK_PER_US - 1);
  localparam logic [c_TW-1:0] c_T2US = c_TW'(2 * CLK_PER_US - 1);
  localparam logic [c_TW-1:0] c_T3US = c_TW'(3 * CLK_PER_US - 1);
  localparam logic [c_TW-1:0] c_TTO  = c_TW'(c_TO_CYC - 1);
  localparam logic [c_TW-1:0] c_TGAP = c_TW'(c_GAP_CYC - 1);

  localparam logic [5:0] c_TX_LAST = 6'd24;
  localparam logic [5:0] c_RX_LAST = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_LO   = 3'd1,
    ST_TX_HI   = 3'd2,
    ST_RX_WAIT = 3'd3,
    ST_RX_BIT  = 3'd4,
    ST_STOP    = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  state_t          r_state;
  logic [c_TW-1:0] r_tmr;
  logic [5:0]      r_cnt;
  logic [24:0]     r_tx;
  logic [63:0]     r_shadow;
  logic [63:0]     r_data;
  logic            r_auto;
  logic            r_rumble;
  logic            r_done;
  logic            r_timeout;
  logic            r_oe;
  logic            r_stop_fell;
  logic [2:0]      r_sync;

  // ---------------- APB decode ----------------
  logic        w_acc;
  logic        w_unmapped;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_start;
  logic        w_rumble_nx;
  logic        w_busy;
  logic        w_fall;
  logic        w_line;
  logic [24:0] w_frame;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_acc       = apb.PSEL & apb.PENABLE;
  assign w_unmapped  = |apb.PADDR[7:4];
  assign w_wr        = w_acc & apb.PWRITE & ~w_unmapped;
  assign w_wr_ctrl   = w_wr & (apb.PADDR[3:2] == 2'd0);
  assign w_wr_stat   = w_wr & (apb.PADDR[3:2] == 2'd1);
  assign w_start     = w_wr_ctrl & apb.PWDATA[0];
  // A START write may carry a new RUMBLE value; the frame must use it.
  assign w_rumble_nx = w_wr_ctrl ? apb.PWDATA[2] : r_rumble;
  assign w_frame     = {16'h4003, 7'd0, w_rumble_nx, 1'b1};
  assign w_busy      = (r_state != ST_IDLE);
  assign w_line      = r_sync[1];
  assign w_fall      = r_sync[2] & ~r_sync[1];
  assign w_unused    = &{1'b0, apb.PADDR[1:0], apb.PWDATA[31:3]};

  always_comb begin
    w_rdata = 32'd0;
    case (apb.PADDR[3:2])
      2'd0:    w_rdata = {29'd0, r_rumble, r_auto, 1'b0};
      2'd1:    w_rdata = {29'd0, r_timeout, r_done, w_busy};
      2'd2:    w_rdata = r_data[63:32];
      default: w_rdata = r_data[31:0];
    endcase
  end

  assign apb.PRDATA  = (w_acc & ~apb.PWRITE & ~w_unmapped) ? w_rdata : 32'd0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_acc & w_unmapped;
  assign GC_DATA_OE  = r_oe;

  // ---------------- CTRL register ----------------
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_auto   <= 1'b0;
      r_rumble <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_auto   <= apb.PWDATA[1];
      r_rumble <= apb.PWDATA[2];
    end
  end

  // ---------------- line synchroniser ----------------
  // Idle-high reset value keeps the edge detector from seeing a false fall.
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) r_sync <= 3'b111;
    else              r_sync <= {r_sync[1:0], GC_DATA_IN};
  end

  // ---------------- poll FSM, status and data ----------------
  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      r_state     <= ST_IDLE;
      r_tmr       <= '0;
      r_cnt       <= 6'd0;
      r_tx        <= 25'd0;
      r_shadow    <= 64'd0;
      r_data      <= 64'd0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_oe        <= 1'b0;
      r_stop_fell <= 1'b0;
    end else begin
      // W1C first so that a completion in the same cycle overrides it.
      if (w_wr_stat) begin
        if (apb.PWDATA[1]) r_done    <= 1'b0;
        if (apb.PWDATA[2]) r_timeout <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_oe <= 1'b0;
          if (w_start) begin
            r_state <= ST_TX_LO;
            r_oe    <= 1'b1;
            r_tx    <= w_frame;
            r_cnt   <= 6'd0;
            r_tmr   <= w_frame[24] ? c_T1US : c_T3US;
          end else if (r_auto) begin
            r_state <= ST_GAP;
            r_tmr   <= c_TGAP;
          end
        end

        ST_GAP: begin
          if (!r_auto) begin
            r_state <= ST_IDLE;
          end else if (r_tmr == '0) begin
            r_state <= ST_TX_LO;
            r_oe    <= 1'b1;
            r_tx    <= w_frame;
            r_cnt   <= 6'd0;
            r_tmr   <= w_frame[24] ? c_T1US : c_T3US;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_TX_LO: begin
          if (r_tmr == '0) begin
            r_state <= ST_TX_HI;
            r_oe    <= 1'b0;
            r_tmr   <= r_tx[24] ? c_T3US : c_T1US;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_TX_HI: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
          end else if (r_cnt == c_TX_LAST) begin
            r_state <= ST_RX_WAIT;
            r_cnt   <= 6'd0;
            r_tmr   <= c_TTO;
          end else begin
            // r_tx[23] becomes the MSB after this shift.
            r_state <= ST_TX_LO;
            r_oe    <= 1'b1;
            r_cnt   <= r_cnt + 6'd1;
            r_tx    <= {r_tx[23:0], 1'b0};
            r_tmr   <= r_tx[23] ? c_T1US : c_T3US;
          end
        end

        ST_RX_WAIT: begin
          if (w_fall) begin
            r_state <= ST_RX_BIT;
            r_tmr   <= c_T2US;
          end else if (r_tmr == '0) begin
            r_timeout <= 1'b1;
            if (r_auto) begin
              r_state <= ST_GAP;
              r_tmr   <= c_TGAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_RX_BIT: begin
          if (r_tmr == '0) begin
            r_shadow <= {r_shadow[62:0], w_line};
            r_tmr    <= c_TTO;
            if (r_cnt == c_RX_LAST) begin
              r_state     <= ST_STOP;
              r_stop_fell <= 1'b0;
            end else begin
              r_state <= ST_RX_WAIT;
              r_cnt   <= r_cnt + 6'd1;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_STOP: begin
          // All 64 bits are in; publish on the stop bit (fall then high),
          // or when the pad never sends one.
          if ((r_stop_fell && w_line) || (r_tmr == '0)) begin
            r_data <= r_shadow;
            r_done <= 1'b1;
            if (r_auto) begin
              r_state <= ST_GAP;
              r_tmr   <= c_TGAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            if (w_fall) r_stop_fell <= 1'b1;
            r_tmr <= r_tmr - 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

`ifdef GC_PAD_IRQ_EN
  logic r_irq;

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) r_irq <= 1'b0;
    else              r_irq <= r_done | r_timeout;
  end

  assign GC_IRQ = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gc_pad_apb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gc_pad_apb
//  Purpose  : Scoreboard bench for gc_pad_apb: APB accesses and TX frames push
//             expectations into queues; monitors pop and compare. A pad model
//             answers polls on the open-drain line.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gc_pad_apb;

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_HI   = 8'h08;
  localparam logic [7:0] A_LO   = 8'h0C;

  logic FAB_CLK     = 1'b0;
  logic M2F_RESET_N = 1'b0;
  logic pad_low     = 1'b0;
  wire  GC_DATA_OE;
  wire  GC_DATA_IN;
`ifdef GC_PAD_IRQ_EN
  wire  GC_IRQ;
`endif

  gc_pad_apb_if bus ();

  gc_pad_apb dut (
    .FAB_CLK     (FAB_CLK),
    .M2F_RESET_N (M2F_RESET_N),
    .apb         (bus),
    .GC_DATA_OE  (GC_DATA_OE),
    .GC_DATA_IN  (GC_DATA_IN)
`ifdef GC_PAD_IRQ_EN
    ,
    .GC_IRQ      (GC_IRQ)
`endif
  );

  always #50 FAB_CLK = ~FAB_CLK;

  // Open-drain line with pull-up.
  assign GC_DATA_IN = ~(GC_DATA_OE | pad_low);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_data   = 64'd0;
  logic        m_done   = 1'b0;
  logic        m_to     = 1'b0;
  logic        m_auto   = 1'b0;
  logic        m_rumble = 1'b0;

  function automatic logic [31:0] st(input logic busy);
    return {29'd0, m_to, m_done, busy};
  endfunction

  // ---------------- APB scoreboard ----------------
  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
    string       nm;
  } acc_t;

  acc_t acc_q[$];

  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input string nm);
    acc_t e;
    e.rd   = ~wr;
    e.data = exp;
    e.err  = (a > A_LO);
    e.nm   = nm;
    acc_q.push_back(e);
    @(posedge FAB_CLK); #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = a;
    bus.PWDATA  = wd;
    @(posedge FAB_CLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge FAB_CLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] wd, input string nm);
    apb_xfer(1'b1, a, wd, 32'd0, nm);
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    apb_xfer(1'b0, a, 32'd0, exp, nm);
  endtask

  always @(negedge FAB_CLK) begin : apb_mon
    acc_t e;
    if (bus.PSEL && bus.PENABLE) begin
      if (acc_q.size() == 0) begin
        chk("apb_access_expected", 64'(acc_q.size()), 64'd1);
      end else begin
        e = acc_q.pop_front();
        chk({e.nm, "_pready"}, 64'(bus.PREADY), 64'd1);
        chk({e.nm, "_pslverr"}, 64'(bus.PSLVERR), 64'(e.err));
        if (e.rd) chk(e.nm, 64'(bus.PRDATA), 64'(e.data));
      end
    end
  end

  // ---------------- TX frame monitor ----------------
  logic [24:0] cmd_q[$];
  logic [63:0] reply_q[$];
  logic [24:0] tx_cmd;
  int          lo_cnt = 0;
  int          tx_idx = 0;
  event        frame_ev;

  always @(negedge FAB_CLK) begin : tx_mon
    logic b;
    if (!M2F_RESET_N) begin
      lo_cnt = 0;
      tx_idx = 0;
    end else if (GC_DATA_OE) begin
      lo_cnt++;
    end else if (lo_cnt != 0) begin
      b = (lo_cnt < 20);
      chk("tx_low_width", 64'(lo_cnt), b ? 64'd10 : 64'd30);
      tx_cmd = {tx_cmd[23:0], b};
      tx_idx++;
      lo_cnt = 0;
      if (tx_idx == 25) begin
        tx_idx = 0;
        if (cmd_q.size() == 0) chk("tx_frame_expected", 64'(cmd_q.size()), 64'd1);
        else                   chk("tx_cmd", 64'(tx_cmd), 64'(cmd_q.pop_front()));
        -> frame_ev;
      end
    end
  end

  // ---------------- pad responder ----------------
  initial begin : responder
    logic [63:0] r;
    forever begin
      @(frame_ev);
      if (reply_q.size() != 0) begin
        r = reply_q.pop_front();
        repeat (50) @(negedge FAB_CLK);
        for (int i = 63; i >= 0; i--) begin
          pad_low = 1'b1;
          repeat (r[i] ? 10 : 30) @(negedge FAB_CLK);
          pad_low = 1'b0;
          repeat (r[i] ? 30 : 10) @(negedge FAB_CLK);
        end
        pad_low = 1'b1;
        repeat (10) @(negedge FAB_CLK);
        pad_low = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge FAB_CLK);
    #1;
  endtask

  task automatic check_irq(input string nm);
`ifdef GC_PAD_IRQ_EN
    chk(nm, 64'(GC_IRQ), 64'(m_done | m_to));
`endif
  endtask

  task automatic clear_status(input logic [31:0] wd, input logic busy);
    apb_write(A_STAT, wd, "wr_status");
    if (wd[1]) m_done = 1'b0;
    if (wd[2]) m_to   = 1'b0;
    @(posedge FAB_CLK); @(negedge FAB_CLK);
    check_irq("irq_after_w1c");
    apb_read(A_STAT, st(busy), "status_after_w1c");
  endtask

  function automatic logic [24:0] cmd_of(input logic rumble);
    return {16'h4003, 7'd0, rumble, 1'b1};
  endfunction

  // One-shot poll; reply==0 means the pad stays silent.
  task automatic poll_once(input logic rumble, input logic reply, input logic [63:0] d);
    cmd_q.push_back(cmd_of(rumble));
    if (reply) reply_q.push_back(d);
    m_rumble = rumble;
    apb_write(A_CTRL, {29'd0, rumble, 2'b01}, "wr_ctrl_start");
    apb_read(A_STAT, st(1'b1), "status_busy");
    // START while busy must not launch a second frame.
    apb_write(A_CTRL, {29'd0, rumble, 2'b01}, "wr_ctrl_restart");
    if (reply) begin
      wait_clk(4000);
      m_data = d;
      m_done = 1'b1;
    end else begin
      wait_clk(1930);
      apb_read(A_STAT, st(1'b1), "status_before_timeout");
      wait_clk(150);
      m_to = 1'b1;
    end
    apb_read(A_STAT, st(1'b0), "status_after_poll");
    apb_read(A_HI, m_data[63:32], "data_hi");
    apb_read(A_LO, m_data[31:0], "data_lo");
    apb_read(A_CTRL, {29'd0, m_rumble, m_auto, 1'b0}, "ctrl");
    check_irq("irq_after_poll");
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cnt;
    logic [63:0] d1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 8'd0;
    bus.PWDATA  = 32'd0;

    // Reset state
    #1;
    chk("oe_in_reset", 64'(GC_DATA_OE), 64'd0);
    repeat (5) @(negedge FAB_CLK);
    M2F_RESET_N = 1'b1;
    wait_clk(2);
    chk("oe_after_reset", 64'(GC_DATA_OE), 64'd0);
    chk("pready_idle", 64'(bus.PREADY), 64'd1);
    check_irq("irq_after_reset");
    apb_read(A_CTRL, 32'd0, "reset_ctrl");
    apb_read(A_STAT, 32'd0, "reset_status");
    apb_read(A_HI, 32'd0, "reset_data_hi");
    apb_read(A_LO, 32'd0, "reset_data_lo");

    // Fixed poll with known reply, then a silent rumble poll
    poll_once(1'b0, 1'b1, 64'h00808080_7F7F2020);
    clear_status(32'h2, 1'b0);
    poll_once(1'b1, 1'b0, 64'd0);

    // Register corner cases
    clear_status(32'h6, 1'b0);
    apb_read(8'h10, 32'd0, "unmapped_rd_0x10");
    apb_write(8'h10, $urandom, "unmapped_wr_0x10");
    apb_read({$urandom_range(4, 63), 2'b00}, 32'd0, "unmapped_rd_rand");
    apb_write(A_HI, $urandom, "wr_ro_data_hi");
    apb_write(A_LO, $urandom, "wr_ro_data_lo");
    apb_read(A_HI, m_data[63:32], "data_hi_after_ro_wr");
    apb_read(A_LO, m_data[31:0], "data_lo_after_ro_wr");

    // Randomised one-shot polls
    for (int k = 0; k < 3; k++) begin
      clear_status($urandom | 32'h6, 1'b0);
      poll_once(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    // AUTO polling, then reset during a TX low phase
    clear_status(32'h6, 1'b0);
    m_rumble = 1'b0;
    m_auto   = 1'b1;
    d1 = {$urandom, $urandom};
    cmd_q.push_back(cmd_of(1'b0));
    reply_q.push_back(d1);
    apb_write(A_CTRL, 32'h2, "wr_ctrl_auto");
    wait_clk(14000);
    m_data = d1;
    m_done = 1'b1;
    apb_read(A_STAT, st(1'b1), "auto_status_in_gap");
    apb_read(A_HI, m_data[63:32], "auto_data_hi");
    apb_read(A_LO, m_data[31:0], "auto_data_lo");
    apb_read(A_CTRL, 32'h2, "auto_ctrl");
    check_irq("auto_irq_set");
    clear_status(32'h2, 1'b1);

    cnt = 0;
    while (!GC_DATA_OE && cnt < 12000) begin
      @(negedge FAB_CLK);
      cnt++;
    end
    chk("auto_second_poll_seen", 64'(GC_DATA_OE), 64'd1);
    chk("auto_gap_long_enough", 64'(cnt >= 9000), 64'd1);
    #20;
    M2F_RESET_N = 1'b0;
    #1;
    chk("oe_async_reset", 64'(GC_DATA_OE), 64'd0);
    m_data = 64'd0; m_done = 1'b0; m_to = 1'b0; m_auto = 1'b0; m_rumble = 1'b0;
    reply_q.delete();
    repeat (5) @(negedge FAB_CLK);
    chk("oe_held_in_reset", 64'(GC_DATA_OE), 64'd0);
    M2F_RESET_N = 1'b1;
    wait_clk(2);
    check_irq("irq_after_reset2");
    apb_read(A_CTRL, 32'd0, "reset2_ctrl");
    apb_read(A_STAT, 32'd0, "reset2_status");
    apb_read(A_HI, 32'd0, "reset2_data_hi");
    apb_read(A_LO, 32'd0, "reset2_data_lo");
    wait_clk(200);
    chk("oe_idle_after_reset2", 64'(GC_DATA_OE), 64'd0);
    chk("tx_frames_outstanding", 64'(cmd_q.size()), 64'd0);
    chk("apb_accesses_outstanding", 64'(acc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #8_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1);
  end

endmodule
`default_nettype wire
